// File: rtl/mux2_arbiter.sv
// Two-requester arbiter driving a shared registered 2:1 data mux, tie-break by last owner.
// Optional ARB_TIMEOUT_EN: bound each ownership to MAX_HOLD cycles when the other side waits.
module mux2_arbiter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ_A,
   input  logic             REQ_B,
   input  logic [WIDTH-1:0] DA,
   input  logic [WIDTH-1:0] DB,
   output logic             GNT_A,
   output logic             GNT_B,
   output logic             SEL,
   output logic [WIDTH-1:0] OUT,
   output logic             VALID
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_e;

   localparam logic LAST_A = 1'b0;
   localparam logic LAST_B = 1'b1;

   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
      $error("mux2_arbiter: MAX_HOLD must be in 1..15");
   end

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic             gnt_a_q, gnt_b_q;
   logic             sel_q;
   logic [WIDTH-1:0] out_q;
   logic             valid_q;
   logic             timeout_s;
   logic [WIDTH-1:0] mux_s;

`ifdef ARB_TIMEOUT_EN
   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
   logic [3:0] hold_q, hold_d;
`endif

   assign mux_s = sel_q ? DB : DA;

   // Next-state arbitration, tie-break and ownership bookkeeping
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_s = (hold_q == HOLD_MAX);
`else
      timeout_s = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (REQ_A && REQ_B) begin
               state_d = (last_q == LAST_B) ? OWN_A : OWN_B;
            end else if (REQ_A) begin
               state_d = OWN_A;
            end else if (REQ_B) begin
               state_d = OWN_B;
            end else begin
               state_d = IDLE;
            end
         end
         OWN_A: begin
            if (REQ_A && !(timeout_s && REQ_B)) begin
               state_d = OWN_A;
            end else if (REQ_B) begin
               state_d = OWN_B;
            end else begin
               state_d = IDLE;
            end
         end
         OWN_B: begin
            if (REQ_B && !(timeout_s && REQ_A)) begin
               state_d = OWN_B;
            end else if (REQ_A) begin
               state_d = OWN_A;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // LAST only moves on entry into an ownership state
      if (state_d == OWN_A && state_q != OWN_A) begin
         last_d = LAST_A;
      end else if (state_d == OWN_B && state_q != OWN_B) begin
         last_d = LAST_B;
      end else begin
         last_d = last_q;
      end

`ifdef ARB_TIMEOUT_EN
      if (state_d != state_q && state_d != IDLE) begin
         hold_d = 4'd1;
      end else if (state_d == IDLE) begin
         hold_d = 4'd0;
      end else if (hold_q < HOLD_MAX) begin
         hold_d = hold_q + 4'd1;
      end else begin
         hold_d = hold_q;
      end
`endif
   end

   // Arbiter state, registered grants/select and captured data path
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         last_q  <= LAST_B;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         sel_q   <= 1'b0;
         out_q   <= {WIDTH{1'b0}};
         valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_q  <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_a_q <= (state_d == OWN_A);
         gnt_b_q <= (state_d == OWN_B);
`ifdef ARB_TIMEOUT_EN
         hold_q  <= hold_d;
`endif
         case (state_d)
            OWN_A:   sel_q <= 1'b0;
            OWN_B:   sel_q <= 1'b1;
            default: sel_q <= sel_q;
         endcase
         if (gnt_a_q || gnt_b_q) begin
            out_q   <= mux_s;
            valid_q <= 1'b1;
         end else begin
            out_q   <= out_q;
            valid_q <= 1'b0;
         end
      end
   end

   assign GNT_A = gnt_a_q;
   assign GNT_B = gnt_b_q;
   assign SEL   = sel_q;
   assign OUT   = out_q;
   assign VALID = valid_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter; expected values are hand-computed.
module tb_mux2_arbiter;

   logic       clk;
   logic       rst;
   logic       req_a;
   logic       req_b;
   logic [7:0] da;
   logic [7:0] db;
   logic       gnt_a;
   logic       gnt_b;
   logic       sel;
   logic [7:0] out_data;
   logic       valid;

   int checks   = 0;
   int failures = 0;

   mux2_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
      .CLK   (clk),
      .RST   (rst),
      .REQ_A (req_a),
      .REQ_B (req_b),
      .DA    (da),
      .DB    (db),
      .GNT_A (gnt_a),
      .GNT_B (gnt_b),
      .SEL   (sel),
      .OUT   (out_data),
      .VALID (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_a;
      rst   = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      da    = 8'h00;
      db    = 8'h00;
      tick();
      tick();
      check_val("rst_gnt_a", 32'(gnt_a), 32'd0);
      check_val("rst_gnt_b", 32'(gnt_b), 32'd0);
      check_val("rst_sel",   32'(sel),   32'd0);
      check_val("rst_out",   32'(out_data), 32'h00);
      check_val("rst_valid", 32'(valid), 32'd0);

      // first tie after reset goes to A
      req_a = 1'b1;
      req_b = 1'b1;
      da    = 8'h3C;
      db    = 8'hC3;
      rst   = 1'b0;
      tick();
      check_val("tie_gnt_a", 32'(gnt_a), 32'd1);
      check_val("tie_gnt_b", 32'(gnt_b), 32'd0);
      check_val("tie_valid0", 32'(valid), 32'd0);
      tick();
      check_val("tie_out", 32'(out_data), 32'h3C);
      check_val("tie_valid1", 32'(valid), 32'd1);

      // handover A -> B with no idle cycle
      req_a = 1'b0;
      da    = 8'h11;
      db    = 8'h5A;
      tick();
      check_val("ho_gnt_a", 32'(gnt_a), 32'd0);
      check_val("ho_gnt_b", 32'(gnt_b), 32'd1);
      check_val("ho_sel",   32'(sel),   32'd1);
      check_val("ho_out_a", 32'(out_data), 32'h11);
      check_val("ho_valid", 32'(valid), 32'd1);
      tick();
      check_val("ho_out_b", 32'(out_data), 32'h5A);
      check_val("ho_gnt_b2", 32'(gnt_b), 32'd1);

      // both drop from OWN_B: SEL holds, VALID falls after the grant goes away
      req_b = 1'b0;
      db    = 8'h77;
      tick();
      check_val("idle_gnt_b", 32'(gnt_b), 32'd0);
      check_val("idle_sel0",  32'(sel),   32'd1);
      check_val("idle_out0",  32'(out_data), 32'h77);
      db = 8'h99;
      tick();
      check_val("idle_valid", 32'(valid), 32'd0);
      check_val("idle_out1",  32'(out_data), 32'h77);
      check_val("idle_sel1",  32'(sel),   32'd1);

      // round robin: A owns, releases, then a tie goes to B
      req_a = 1'b1;
      tick();
      check_val("rr_gnt_a", 32'(gnt_a), 32'd1);
      check_val("rr_sel_a", 32'(sel),   32'd0);
      req_a = 1'b0;
      tick();
      check_val("rr_idle", 32'(gnt_a | gnt_b), 32'd0);
      req_a = 1'b1;
      req_b = 1'b1;
      tick();
      check_val("rr_tie_b", 32'(gnt_b), 32'd1);
      check_val("rr_tie_a", 32'(gnt_a), 32'd0);

      // get into OWN_A with data flowing, then reset asynchronously
      req_b = 1'b0;
      da    = 8'hA5;
      tick();
      check_val("ar_gnt_a", 32'(gnt_a), 32'd1);
      tick();
      check_val("ar_out",   32'(out_data), 32'hA5);
      check_val("ar_valid", 32'(valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_val("async_gnt_a", 32'(gnt_a), 32'd0);
      check_val("async_valid", 32'(valid), 32'd0);
      check_val("async_out",   32'(out_data), 32'h00);
      check_val("async_sel",   32'(sel),   32'd0);

      // sustained contention after reset
      req_a = 1'b1;
      req_b = 1'b1;
      tick();
      check_val("hold_rst_gnt", 32'(gnt_a | gnt_b), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
`ifdef ARB_TIMEOUT_EN
         exp_a = ((i / 4) % 2) == 0;
`else
         exp_a = 1'b1;
`endif
         check_val($sformatf("cont_gnt_a_%0d", i), 32'(gnt_a), 32'(exp_a));
         check_val($sformatf("cont_gnt_b_%0d", i), 32'(gnt_b), 32'(!exp_a));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
